// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and
// the width/offset legality check used by the request decoder.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } lsu_state_t;

  // Unsigned variants exist only for loads.
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response channel and data memory port of the load/store unit.
interface load_store_unit_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_fault;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: load extract with extension, and store merge
// of new data into the old word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_off,
  input  logic [XLEN-1:0] i_word,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_ldata,
  output logic [XLEN-1:0] o_sdata
);

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_bmask;
  logic [XLEN-1:0] w_hmask;
  logic [4:0]      w_shamt;

  always_comb begin
    w_shamt = {i_off, 3'b000};
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half  = i_off[1] ? i_word[31:16] : i_word[15:0];
    w_bmask = {{(XLEN-8){1'b0}}, 8'hFF} << w_shamt;
    w_hmask = {{(XLEN-16){1'b0}}, 16'hFFFF} << w_shamt;

    case (i_funct3)
      F3_B:    o_ldata = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_H:    o_ldata = {{(XLEN-16){w_half[15]}}, w_half};
      F3_W:    o_ldata = i_word;
      F3_BU:   o_ldata = {{(XLEN-8){1'b0}}, w_byte};
      F3_HU:   o_ldata = {{(XLEN-16){1'b0}}, w_half};
      default: o_ldata = '0;
    endcase

    case (i_funct3)
      F3_B:    o_sdata = (i_word & ~w_bmask) |
                         (({{(XLEN-8){1'b0}}, i_wdata[7:0]} << w_shamt) & w_bmask);
      F3_H:    o_sdata = (i_word & ~w_hmask) |
                         (({{(XLEN-16){1'b0}}, i_wdata[15:0]} << w_shamt) & w_hmask);
      F3_W:    o_sdata = i_wdata;
      default: o_sdata = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the MEM stage and a word-addressed data
// memory with combinational read; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  lsu_state_t      r_state;
  lsu_state_t      w_next;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_old;
  logic [XLEN-1:0] r_rdata;
  logic            r_fault;

  logic            w_accept;
  logic            w_fault;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_ldata;
  logic [XLEN-1:0] w_sdata;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  assign w_fault  = !access_legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]) ||
                    ({2'b00, bus.req_addr[XLEN-1:2]} >= XLEN'(DEPTH_WORDS));
  // Loads extract straight from memory; stores merge into the captured old word.
  assign w_word   = (r_state == S_LOAD) ? bus.mem_rdata : r_old;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_addr[1:0]),
    .i_word   (w_word),
    .i_wdata  (r_wdata),
    .o_ldata  (w_ldata),
    .o_sdata  (w_sdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fault)                     w_next = S_RESP;
          else if (!bus.req_we)            w_next = S_LOAD;
          else if (bus.req_funct3 == F3_W) w_next = S_WRITE;
          else                             w_next = S_RMW_RD;
        end
      end
      S_LOAD:   w_next = S_RESP;
      S_RMW_RD: w_next = S_WRITE;
      S_WRITE:  w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_old    <= '0;
      r_rdata  <= '0;
      r_fault  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_fault) begin
            r_rdata <= '0;
            r_fault <= 1'b1;
          end
        end
        S_LOAD: begin
          r_rdata <= w_ldata;
          r_fault <= 1'b0;
        end
        S_RMW_RD: r_old <= bus.mem_rdata;
        S_WRITE: begin
          r_rdata <= '0;
          r_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = (r_state == S_IDLE);
    bus.resp_valid = (r_state == S_RESP);
    bus.resp_rdata = r_rdata;
    bus.resp_fault = r_fault;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (r_state == S_LOAD || r_state == S_RMW_RD || r_state == S_WRITE)
      bus.mem_addr = {r_addr[XLEN-1:2], 2'b00};
    if (r_state == S_WRITE) begin
      bus.mem_we    = r_we;
      bus.mem_wdata = w_sdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(32)) bus();

  load_store_unit #(.XLEN(32), .DEPTH_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;
  int          we_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we) begin
      mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
      we_cnt    <= we_cnt + 1;
      last_addr <= bus.mem_addr;
      last_data <= bus.mem_wdata;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      exp_t e;
      int   lat;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: rdata=%h fault=%b with no request outstanding",
                 bus.resp_rdata, bus.resp_fault);
      end else begin
        e   = sb.pop_front();
        lat = cyc - e.acc + 1;
        if (bus.resp_rdata !== e.rdata || bus.resp_fault !== e.fault || lat != e.lat) begin
          bad++;
          $display("FAIL resp: got rdata=%h fault=%b lat=%0d, want rdata=%h fault=%b lat=%0d",
                   bus.resp_rdata, bus.resp_fault, lat, e.rdata, e.fault, e.lat);
        end
      end
    end
  end

  task automatic poke(input logic [31:0] byte_addr, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = byte_addr[11:2]; bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Drives a request (valid stays high afterwards) and returns after the acceptance edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_fault, input int exp_lat, input bit expect_resp);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready=%b, want 1 within 50 cycles", bus.req_ready);
    end else begin
      e.rdata = exp_rdata; e.fault = exp_fault; e.lat = exp_lat; e.acc = cyc + 1;
      if (expect_resp) sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.req_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_busy: req_ready=%b, want 0 after acceptance", bus.req_ready);
      end
    end
  endtask

  task automatic drop_and_drain();
    int n;
    bus.req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL resp_timeout: %0d responses outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;
    #12;
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
        bus.resp_fault !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 ||
        bus.mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset: ready=%b rv=%b rd=%h rf=%b we=%b ma=%h mw=%h, want 1 0 0 0 0 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_fault,
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads();
    poke(32'h10, 32'h8844_2211);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0088, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8844, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b000, 32'h10, 32'h0, 32'h0000_0011, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8844_2211, 1'b0, 2, 1'b1);
    drop_and_drain();
  endtask

  task automatic test_sb();
    int c0;
    poke(32'h20, 32'h1122_3344);
    c0 = we_cnt;
    issue(1'b1, 3'b000, 32'h21, 32'h0000_00AB, 32'h0, 1'b0, 3, 1'b1);
    drop_and_drain();
    total++;
    if (we_cnt != c0 + 1 || last_addr !== 32'h20 || last_data !== 32'h1122_AB44) begin
      bad++;
      $display("FAIL sb_write: writes=%0d addr=%h data=%h, want 1 00000020 1122ab44",
               we_cnt - c0, last_addr, last_data);
    end
  endtask

  task automatic test_sh_then_lhu();
    poke(32'h40, 32'h0);
    issue(1'b1, 3'b001, 32'h42, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1'b1);
    issue(1'b0, 3'b101, 32'h42, 32'h0, 32'h0000_BEEF, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF_BEEF, 1'b0, 2, 1'b1);
    drop_and_drain();
    total++;
    if (mem[16] !== 32'hBEEF_0000) begin
      bad++;
      $display("FAIL sh_word: mem[0x40]=%h, want beef0000", mem[16]);
    end
  endtask

  task automatic test_faults();
    int c0;
    poke(32'hFFC, 32'hCAFE_F00D);
    c0 = we_cnt;
    issue(1'b0, 3'b010, 32'h06,   32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b001, 32'h03,   32'h1234, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b011, 32'h00,   32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b100, 32'h00,   32'h55, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b010, 32'h1000, 32'h77, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b010, 32'hFFC,  32'h0, 32'hCAFE_F00D, 1'b0, 2, 1'b1);
    drop_and_drain();
    total++;
    if (we_cnt != c0) begin
      bad++;
      $display("FAIL fault_no_write: writes=%0d, want 0", we_cnt - c0);
    end
  endtask

  task automatic test_reset_mid_write();
    int c0;
    poke(32'h30, 32'h5566_7788);
    c0 = we_cnt;
    issue(1'b1, 3'b000, 32'h31, 32'h0000_00CC, 32'h0, 1'b0, 3, 1'b0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_we !== 1'b1) begin
      bad++;
      $display("FAIL write_cycle: mem_we=%b, want 1 in the write cycle", bus.mem_we);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL rst_abort: mem_we=%b, want 0 under reset", bus.mem_we);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1 || we_cnt != c0 || mem[12] !== 32'h5566_7788 ||
        bus.resp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_after: ready=%b writes=%0d word=%h rdata=%h, want 1 0 55667788 0",
               bus.req_ready, we_cnt - c0, mem[12], bus.resp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = we_cnt;
    issue(1'b1, 3'b010, 32'h50, 32'h0102_0304, 32'h0, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h50, 32'h0, 32'h0102_0304, 1'b0, 2, 1'b1);
    issue(1'b1, 3'b000, 32'h51, 32'h0000_00EE, 32'h0, 1'b0, 3, 1'b1);
    issue(1'b0, 3'b100, 32'h51, 32'h0, 32'h0000_00EE, 1'b0, 2, 1'b1);
    drop_and_drain();
    total++;
    if (we_cnt != c0 + 2 || mem[20] !== 32'h0102_EE04) begin
      bad++;
      $display("FAIL b2b_mem: writes=%0d word=%h, want 2 0102ee04", we_cnt - c0, mem[20]);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sb();
    test_sh_then_lhu();
    test_faults();
    test_reset_mid_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
